// File: rtl/axi_burst_wr_master.sv
// ---------------------------------------------------------------------------
// axi_burst_wr_master
//
// Splits one user write command (start address + beat count) into a series
// of AXI INCR bursts. A burst never exceeds MAX_BURST beats and never crosses
// a 4 KB boundary. Only one burst is in flight at a time: AW, then all of its
// W beats, then its B response, before the next AW is issued.
//
// Ports
//   clk, rst                 : rising-edge clock, synchronous active-high reset
//   wr_trig/wr_addr/wr_beats : command strobe, start byte address, beat count
//   wr_data/wr_data_valid    : user write data stream
//   wr_data_ready            : a user beat is consumed this cycle
//   wr_ready                 : idle, ready to accept a command
//   wr_done                  : one-cycle pulse at the end of a command
//   wr_err                   : sticky, some burst in the command got a non-OKAY response
//   axi_aw*                  : AXI write-address channel
//   axi_w*                   : AXI write-data channel
//   axi_b*                   : AXI write-response channel
// ---------------------------------------------------------------------------
module axi_burst_wr_master #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_trig,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [15:0]               wr_beats,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      wr_data_valid,
  output logic                      wr_data_ready,
  output logic                      wr_ready,
  output logic                      wr_done,
  output logic                      wr_err,
  output logic                      axi_awvalid,
  output logic [ADDR_WIDTH-1:0]     axi_awaddr,
  output logic [7:0]                axi_awlen,
  output logic [2:0]                axi_awsize,
  output logic [1:0]                axi_awburst,
  input  logic                      axi_awready,
  output logic                      axi_wvalid,
  output logic [DATA_WIDTH-1:0]     axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   axi_wstrb,
  output logic                      axi_wlast,
  input  logic                      axi_wready,
  input  logic                      axi_bvalid,
  input  logic [1:0]                axi_bresp,
  output logic                      axi_bready
);

  localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
  localparam int SIZE_LOG2      = $clog2(BYTES_PER_BEAT);
  localparam logic [8:0] MAX_LEN = 9'(MAX_BURST);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES_PER_BEAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    AW,
    W,
    B,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [15:0]             remaining_q, remaining_d;
  logic [8:0]              burst_len_q, burst_len_d;
  logic [8:0]              beat_cnt_q, beat_cnt_d;
  logic                    err_q, err_d;

  logic [12:0]             boundary_beats;
  logic [8:0]              next_len;
  logic                    w_hs;
  logic                    last_beat;

  // Length of the burst about to be issued: the smallest of the configured
  // maximum, the beats left before the next 4 KB page, and the beats still
  // owed on this command. addr_q and remaining_q only change in IDLE and B,
  // so this value is stable for the whole time AW is presented.
  always_comb begin
    boundary_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> SIZE_LOG2;
    next_len = MAX_LEN;
    if ({3'd0, boundary_beats} < {7'd0, next_len}) begin
      next_len = boundary_beats[8:0];
    end
    if (remaining_q < {7'd0, next_len}) begin
      next_len = remaining_q[8:0];
    end
  end

  assign w_hs      = (state_q == W) && wr_data_valid && axi_wready;
  assign last_beat = (beat_cnt_q == (burst_len_q - 9'd1));

  // Next-state and datapath update. The burst length is captured at the AW
  // handshake so that the W beat count and the B address step use exactly
  // the length that was advertised on awlen.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    burst_len_d = burst_len_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (wr_trig) begin
          err_d = 1'b0;
          if (wr_beats != 16'd0) begin
            addr_d      = wr_addr & ALIGN_MASK;
            remaining_d = wr_beats;
            state_d     = AW;
          end else begin
            state_d = DONE;
          end
        end
      end
      AW: begin
        if (axi_awready) begin
          burst_len_d = next_len;
          beat_cnt_d  = 9'd0;
          state_d     = W;
        end
      end
      W: begin
        if (w_hs) begin
          if (last_beat) begin
            beat_cnt_d = 9'd0;
            state_d    = B;
          end else begin
            beat_cnt_d = beat_cnt_q + 9'd1;
          end
        end
      end
      B: begin
        if (axi_bvalid) begin
          if (axi_bresp != 2'b00) begin
            err_d = 1'b1;
          end
          // Wraps silently at the top of the address space.
          addr_d      = addr_q + (ADDR_WIDTH'(burst_len_q) << SIZE_LOG2);
          remaining_d = remaining_q - {7'd0, burst_len_q};
          state_d     = (remaining_d != 16'd0) ? AW : DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset abandons any burst in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= 16'd0;
      burst_len_q <= 9'd0;
      beat_cnt_q  <= 9'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      burst_len_q <= burst_len_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
    end
  end

  assign wr_ready      = (state_q == IDLE);
  assign wr_done       = (state_q == DONE);
  assign wr_err        = err_q;
  assign wr_data_ready = w_hs;

  assign axi_awvalid = (state_q == AW);
  assign axi_awaddr  = addr_q;
  assign axi_awlen   = (state_q == AW) ? 8'(next_len - 9'd1) : 8'd0;
  assign axi_awsize  = 3'(SIZE_LOG2);
  assign axi_awburst = 2'b01;

  assign axi_wvalid = (state_q == W) && wr_data_valid;
  assign axi_wdata  = (state_q == W) ? wr_data : '0;
  assign axi_wstrb  = '1;
  assign axi_wlast  = (state_q == W) && last_beat;

  assign axi_bready = (state_q == B);

endmodule

// File: tb/tb_axi_burst_wr_master.sv
// ---------------------------------------------------------------------------
// tb_axi_burst_wr_master
//
// Drives directed write commands into axi_burst_wr_master and models a
// simple AXI slave plus user data source. Expected AW bursts, W beats and
// end-of-command error flags are queued when each command is issued; a
// monitor pops and compares them as the DUT presents each transfer.
// ---------------------------------------------------------------------------
module tb_axi_burst_wr_master;

  localparam int AW_W = 26;
  localparam int DW   = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_trig;
  logic [AW_W-1:0]  wr_addr;
  logic [15:0]      wr_beats;
  logic [DW-1:0]    wr_data;
  logic             wr_data_valid;
  logic             wr_data_ready;
  logic             wr_ready;
  logic             wr_done;
  logic             wr_err;
  logic             axi_awvalid;
  logic [AW_W-1:0]  axi_awaddr;
  logic [7:0]       axi_awlen;
  logic [2:0]       axi_awsize;
  logic [1:0]       axi_awburst;
  logic             axi_awready;
  logic             axi_wvalid;
  logic [DW-1:0]    axi_wdata;
  logic [DW/8-1:0]  axi_wstrb;
  logic             axi_wlast;
  logic             axi_wready;
  logic             axi_bvalid;
  logic [1:0]       axi_bresp;
  logic             axi_bready;

  axi_burst_wr_master #(
    .ADDR_WIDTH(AW_W),
    .DATA_WIDTH(DW),
    .MAX_BURST (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_trig      (wr_trig),
    .wr_addr      (wr_addr),
    .wr_beats     (wr_beats),
    .wr_data      (wr_data),
    .wr_data_valid(wr_data_valid),
    .wr_data_ready(wr_data_ready),
    .wr_ready     (wr_ready),
    .wr_done      (wr_done),
    .wr_err       (wr_err),
    .axi_awvalid  (axi_awvalid),
    .axi_awaddr   (axi_awaddr),
    .axi_awlen    (axi_awlen),
    .axi_awsize   (axi_awsize),
    .axi_awburst  (axi_awburst),
    .axi_awready  (axi_awready),
    .axi_wvalid   (axi_wvalid),
    .axi_wdata    (axi_wdata),
    .axi_wstrb    (axi_wstrb),
    .axi_wlast    (axi_wlast),
    .axi_wready   (axi_wready),
    .axi_bvalid   (axi_bvalid),
    .axi_bresp    (axi_bresp),
    .axi_bready   (axi_bready)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW_W-1:0] addr;
    logic [7:0]      len;
  } aw_exp_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } w_exp_t;

  aw_exp_t     awQ[$];
  w_exp_t      wQ[$];
  logic        doneQ[$];
  logic [31:0] dataSrc[$];
  logic [1:0]  respQ[$];
  int          pendLens[$];

  int   compared   = 0;
  int   mismatched = 0;
  int   cycle      = 0;
  int   trigCycle  = 0;
  int   doneCycle  = 0;
  int   wBeatCount = 0;
  int   stallLeft  = 0;
  logic gapMode    = 1'b0;
  logic burstOpen  = 1'b0;
  logic wOpen      = 1'b0;

  // Free-running cycle counter, used to measure wr_done latency.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Queue one expected burst (hand-computed address and awlen).
  task automatic expectBurst(input logic [AW_W-1:0] addr, input logic [7:0] len);
    awQ.push_back('{addr: addr, len: len});
    pendLens.push_back(int'(len) + 1);
  endtask

  // Build the data stream and expected W beats for the bursts queued so far,
  // then strobe the command for one cycle once the DUT is idle.
  task automatic applyStimulus(input logic [AW_W-1:0] addr, input logic [15:0] beats,
                               input logic [31:0] seed, input logic expErr);
    int idx = 0;
    foreach (pendLens[k]) begin
      for (int j = 0; j < pendLens[k]; j++) begin
        dataSrc.push_back(seed + 32'(idx));
        wQ.push_back('{data: seed + 32'(idx), last: (j == pendLens[k] - 1)});
        idx++;
      end
    end
    pendLens.delete();
    doneQ.push_back(expErr);
    @(posedge clk); #1;
    for (int i = 0; i < 200 && !wr_ready; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("ready_before_trig", 64'(wr_ready), 64'd1);
    wr_trig   = 1'b1;
    wr_addr   = addr;
    wr_beats  = beats;
    trigCycle = cycle;
    @(posedge clk); #1;
    wr_trig = 1'b0;
  endtask

  // Bounded wait for the command's wr_done, then confirm nothing expected is left over.
  task automatic waitDone(input string name);
    for (int i = 0; i < 3000 && doneQ.size() != 0; i++) @(negedge clk);
    checkOutput({name, "_done_pending"}, 64'(doneQ.size()), 64'd0);
    checkOutput({name, "_aw_left"}, 64'(awQ.size()), 64'd0);
    checkOutput({name, "_w_left"}, 64'(wQ.size()), 64'd0);
    doneQ.delete();
  endtask

  // Monitor: samples on the falling edge, pops expectations as the DUT
  // presents AW, W and done events, and flags any protocol-order violation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (axi_awvalid) begin
          if (burstOpen) checkOutput("aw_while_outstanding", 64'(axi_awvalid), 64'd0);
          if (awQ.size() == 0) begin
            checkOutput("unexpected_aw", 64'(axi_awvalid), 64'd0);
          end else begin
            checkOutput("awaddr", 64'(axi_awaddr), 64'(awQ[0].addr));
            checkOutput("awlen", 64'(axi_awlen), 64'(awQ[0].len));
            if (axi_awready) begin
              checkOutput("awsize", 64'(axi_awsize), 64'd2);
              checkOutput("awburst", 64'(axi_awburst), 64'd1);
              void'(awQ.pop_front());
              burstOpen = 1'b1;
              wOpen     = 1'b1;
            end
          end
        end
        if (axi_wvalid && !wOpen) checkOutput("w_before_aw", 64'(axi_wvalid), 64'd0);
        if (axi_wvalid && axi_wready) begin
          wBeatCount++;
          if (wQ.size() == 0) begin
            checkOutput("unexpected_wbeat", 64'(axi_wvalid), 64'd0);
          end else begin
            checkOutput("wdata", 64'(axi_wdata), 64'(wQ[0].data));
            checkOutput("wlast", 64'(axi_wlast), 64'(wQ[0].last));
            checkOutput("wstrb", 64'(axi_wstrb), 64'hF);
            if (wQ[0].last) wOpen = 1'b0;
            void'(wQ.pop_front());
          end
        end
        if (axi_bvalid && axi_bready) burstOpen = 1'b0;
        if (wr_done) begin
          doneCycle = cycle;
          if (doneQ.size() == 0) begin
            checkOutput("unexpected_done", 64'(wr_done), 64'd0);
          end else begin
            checkOutput("err_at_done", 64'(wr_err), 64'(doneQ[0]));
            void'(doneQ.pop_front());
          end
        end
      end
    end
  end

  // Slave and user data source: sample handshakes on the falling edge,
  // update the driven inputs just after the following rising edge.
  initial begin
    logic consumed, wlastHs, bHs;
    forever begin
      @(negedge clk);
      consumed = wr_data_ready;
      wlastHs  = axi_wvalid && axi_wready && axi_wlast;
      bHs      = axi_bvalid && axi_bready;
      @(posedge clk); #1;
      if (consumed && dataSrc.size() > 0) void'(dataSrc.pop_front());
      if (bHs) axi_bvalid = 1'b0;
      if (wlastHs) begin
        axi_bvalid = 1'b1;
        axi_bresp  = 2'b00;
        if (respQ.size() > 0) axi_bresp = respQ.pop_front();
      end
      if (axi_awvalid && stallLeft > 0) begin
        stallLeft--;
        axi_awready = 1'b0;
      end else begin
        axi_awready = axi_awvalid;
      end
      axi_wready    = gapMode ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_data_valid = (dataSrc.size() > 0) && (gapMode ? 1'($urandom_range(0, 1)) : 1'b1);
      wr_data       = (dataSrc.size() > 0) ? dataSrc[0] : 32'd0;
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int base;
    rst           = 1'b1;
    wr_trig       = 1'b0;
    wr_addr       = '0;
    wr_beats      = 16'd0;
    wr_data       = '0;
    wr_data_valid = 1'b0;
    axi_awready   = 1'b0;
    axi_wready    = 1'b0;
    axi_bvalid    = 1'b0;
    axi_bresp     = 2'b00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_wr_ready", 64'(wr_ready), 64'd1);
    checkOutput("rst_awvalid", 64'(axi_awvalid), 64'd0);
    checkOutput("rst_wvalid", 64'(axi_wvalid), 64'd0);
    checkOutput("rst_wlast", 64'(axi_wlast), 64'd0);
    checkOutput("rst_bready", 64'(axi_bready), 64'd0);
    checkOutput("rst_wr_done", 64'(wr_done), 64'd0);
    checkOutput("rst_wr_err", 64'(wr_err), 64'd0);
    checkOutput("rst_awaddr", 64'(axi_awaddr), 64'd0);
    checkOutput("rst_awlen", 64'(axi_awlen), 64'd0);
    checkOutput("rst_awsize", 64'(axi_awsize), 64'd2);
    checkOutput("rst_awburst", 64'(axi_awburst), 64'd1);
    checkOutput("rst_wstrb", 64'(axi_wstrb), 64'hF);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] 40 beats from 0x100");
    expectBurst(26'h100, 8'd15);
    expectBurst(26'h140, 8'd15);
    expectBurst(26'h180, 8'd7);
    applyStimulus(26'h100, 16'd40, 32'hA000_0000, 1'b0);
    waitDone("t1");

    $display("[TB] 4 beats from 0xFF8 across a 4 KB page");
    expectBurst(26'hFF8, 8'd1);
    expectBurst(26'h1000, 8'd1);
    applyStimulus(26'hFF8, 16'd4, 32'hB000_0000, 1'b0);
    waitDone("t2");

    $display("[TB] zero-beat command");
    applyStimulus(26'h500, 16'd0, 32'hC000_0000, 1'b0);
    waitDone("t3");
    // Rising edges from the one launching wr_trig to the one capturing wr_done.
    checkOutput("zero_done_latency", 64'(doneCycle + 1 - trigCycle), 64'd2);

    $display("[TB] awready stall and random data gaps");
    stallLeft = 5;
    gapMode   = 1'b1;
    expectBurst(26'h2000, 8'd15);
    expectBurst(26'h2040, 8'd3);
    applyStimulus(26'h2000, 16'd20, 32'hD000_0000, 1'b0);
    waitDone("t4");
    gapMode = 1'b0;

    $display("[TB] SLVERR on burst 2 of 3");
    respQ.push_back(2'b00);
    respQ.push_back(2'b10);
    respQ.push_back(2'b00);
    expectBurst(26'h0, 8'd15);
    expectBurst(26'h40, 8'd15);
    expectBurst(26'h80, 8'd7);
    applyStimulus(26'h0, 16'd40, 32'hE000_0000, 1'b1);
    waitDone("t5");
    repeat (3) begin
      @(negedge clk);
      checkOutput("err_held", 64'(wr_err), 64'd1);
    end

    $display("[TB] unaligned command clears the error");
    expectBurst(26'h300, 8'd2);
    applyStimulus(26'h303, 16'd3, 32'hF000_0000, 1'b0);
    @(negedge clk);
    checkOutput("err_cleared", 64'(wr_err), 64'd0);
    waitDone("t6");

    $display("[TB] reset in the middle of a burst");
    base = wBeatCount;
    expectBurst(26'h400, 8'd15);
    applyStimulus(26'h400, 16'd16, 32'h1234_0000, 1'b0);
    for (int i = 0; i < 200 && wBeatCount < base + 5; i++) @(negedge clk);
    checkOutput("beats_before_rst", 64'(wBeatCount >= base + 5), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_wvalid", 64'(axi_wvalid), 64'd0);
    checkOutput("rst_mid_wr_ready", 64'(wr_ready), 64'd1);
    checkOutput("rst_mid_awvalid", 64'(axi_awvalid), 64'd0);
    checkOutput("rst_mid_bready", 64'(axi_bready), 64'd0);
    awQ.delete();
    wQ.delete();
    doneQ.delete();
    dataSrc.delete();
    respQ.delete();
    axi_bvalid = 1'b0;
    burstOpen  = 1'b0;
    wOpen      = 1'b0;

    $display("[TB] command after reset");
    expectBurst(26'h800, 8'd4);
    applyStimulus(26'h800, 16'd5, 32'h5555_0000, 1'b0);
    waitDone("t8");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axi_burst_wr_master.md
AXI_BURST_WR_MASTER -- requirements
Module: axi_burst_wr_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 26: AXI byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: beat width; legal values are 16, 32, 64 and 128.
REQ-003 SHALL have parameter MAX_BURST, default 16: maximum beats per AXI burst; legal range is 1..256.
REQ-004 SHALL have clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have wr_trig, input, 1: command strobe, sampled only while wr_ready=1.
REQ-007 SHALL have wr_addr, input, ADDR_WIDTH: start byte address; the low log2(DATA_WIDTH/8) bits are ignored and treated as 0.
REQ-008 SHALL have wr_beats, input, 16: total beats in the command.
REQ-009 SHALL have wr_data, input, DATA_WIDTH: user write data.
REQ-010 SHALL have wr_data_valid, input, 1: wr_data is valid.
REQ-011 SHALL have wr_data_ready, output, 1: the beat is consumed this cycle.
REQ-012 SHALL have wr_ready (output, 1: idle, command accepted), wr_done (output, 1: one-cycle end-of-command pulse) and wr_err (output, 1: the command saw a non-OKAY response).
REQ-013 SHALL have AXI AW outputs: axi_awvalid (1), axi_awaddr (ADDR_WIDTH), axi_awlen (8), axi_awsize (3), axi_awburst (2); and input axi_awready (1).
REQ-014 SHALL have AXI W outputs: axi_wvalid (1), axi_wdata (DATA_WIDTH), axi_wstrb (DATA_WIDTH/8), axi_wlast (1); and input axi_wready (1).
REQ-015 SHALL have AXI B inputs axi_bvalid (1) and axi_bresp (2), and output axi_bready (1).

Function
REQ-016 SHALL use a state machine with states IDLE, AW, W, B and DONE.
REQ-017 SHALL set wr_ready=1 only in IDLE.
REQ-018 SHALL, in IDLE with wr_trig=1 and wr_beats>0, register the aligned address and the beat count, clear wr_err, and move to AW.
REQ-019 SHALL, in IDLE with wr_trig=1 and wr_beats=0, move straight to DONE with no AXI activity.
REQ-020 SHALL set each burst length to min(remaining beats, MAX_BURST, beats left to the next 4 KB boundary); beats left to the boundary = (4096 - addr[11:0]) / (DATA_WIDTH/8).
REQ-021 SHALL drive the AW channel in AW as follows: axi_awvalid=1, axi_awlen = burst length - 1, axi_awsize = log2(DATA_WIDTH/8), axi_awburst = 2'b01 (INCR).
REQ-022 SHALL hold all AW fields stable until axi_awready is sampled high, then deassert axi_awvalid and move to W on the next cycle.
REQ-023 SHALL, in W, combine the handshakes as: axi_wvalid = wr_data_valid; wr_data_ready = axi_wready AND wr_data_valid; axi_wdata = wr_data; axi_wstrb = all ones.
REQ-024 SHALL assert axi_wlast on the final beat of each burst only.
REQ-025 SHALL move from W to B after the last beat handshake.
REQ-026 SHALL set axi_bready=1 only in B.
REQ-027 SHALL, on axi_bvalid in B, set wr_err if axi_bresp != 2'b00 (the flag is sticky for the command) and advance the address by burst length × DATA_WIDTH/8.
REQ-028 SHALL, after that B handshake, subtract the burst length from the remaining count and go to AW if the count is non-zero, else to DONE.
REQ-029 SHALL pulse wr_done for exactly one cycle in DONE, then return to IDLE.
REQ-030 SHALL hold wr_err until the next accepted command.
REQ-031 SHALL allow only one burst outstanding; the next AW is not issued until the B response has been received.
REQ-032 SHALL keep axi_wvalid=0 outside W; a W beat never precedes its AW handshake.
REQ-033 SHALL let address arithmetic wrap modulo 2^ADDR_WIDTH without flagging.

Reset
REQ-034 SHALL, while rst=1, force the state to IDLE on the next edge, including mid-burst, abandoning any transfer without completing it.
REQ-035 SHALL reset all outputs to 0 (axi_awvalid, axi_wvalid, axi_wlast, axi_bready, wr_data_ready, wr_done, wr_err, axi_awaddr, axi_awlen), except: wr_ready=1; axi_awsize, axi_awburst and axi_wstrb, which are constants.

Verification
REQ-036 SHALL cover this scenario: DATA_WIDTH=32, MAX_BURST=16, wr_addr=0x100, wr_beats=40, always-ready slave -> three bursts, awaddr 0x100/0x140/0x180, awlen 15/15/7; wlast on beats 16, 32 and 40; one wr_done pulse.
REQ-037 SHALL cover this scenario: wr_addr=0xFF8, wr_beats=4 -> burst 1 is awaddr 0xFF8 with awlen 1; burst 2 is awaddr 0x1000 with awlen 1; no burst crosses 0x1000.
REQ-038 SHALL cover this scenario: wr_beats=0 -> no awvalid, and wr_done pulses 2 cycles after wr_trig.
REQ-039 SHALL cover this scenario: axi_awready held low for 5 cycles, then random wr_data_valid/axi_wready gaps -> AW fields stable throughout, exactly wr_beats data handshakes, data order preserved.
REQ-040 SHALL cover this scenario: bresp=2'b10 on burst 2 of 3 -> all 3 bursts complete; wr_err=1 at wr_done and held; cleared on the next wr_trig.
REQ-041 SHALL cover this scenario: rst asserted during W at beat 5 -> next cycle axi_wvalid=0 and wr_ready=1; a new command afterwards runs correctly.
